// File: rtl/herald_pkg.sv
// -----------------------------------------------------------------------------
// herald_pkg
//   Shared definitions for the Herald host command port:
//   - command code constants
//   - cmd_num_ops():   operands needed by a command (0, 1, 2 or OPS_INVALID)
//   - cmd_res_bytes(): result length in bytes returned by a command
//   - state_t:         command port FSM states
// -----------------------------------------------------------------------------
package herald_pkg;

  localparam logic [7:0] CMD_SINCOS    = 8'h10;
  localparam logic [7:0] CMD_SQRT      = 8'h11;
  localparam logic [7:0] CMD_RECIP     = 8'h12;
  localparam logic [7:0] CMD_NORMALIZE = 8'h13;
  localparam logic [7:0] CMD_MULTIPLY  = 8'h20;
  localparam logic [7:0] CMD_DIVIDE    = 8'h21;
  localparam logic [7:0] CMD_CLEAR     = 8'h22;
  localparam logic [7:0] CMD_IDENT     = 8'h23;

  // Operand-count code reserved for commands the engine mux does not know.
  localparam logic [1:0] OPS_INVALID = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPA,
    ST_OPB,
    ST_START,
    ST_WAIT,
    ST_RESULT
  } state_t;

  function automatic logic [1:0] cmd_num_ops(input logic [7:0] cmd);
    case (cmd)
      CMD_SINCOS, CMD_SQRT, CMD_RECIP, CMD_NORMALIZE: return 2'd1;
      CMD_MULTIPLY, CMD_DIVIDE:                       return 2'd2;
      CMD_CLEAR, CMD_IDENT:                           return 2'd0;
      default:                                        return OPS_INVALID;
    endcase
  endfunction

  function automatic logic [3:0] cmd_res_bytes(input logic [7:0] cmd);
    case (cmd)
      CMD_SINCOS:    return 4'd6;
      CMD_NORMALIZE: return 4'd9;
      CMD_CLEAR:     return 4'd0;
      default:       return 4'd3;
    endcase
  endfunction

endpackage

// File: rtl/herald_cmd_port_if.sv
// -----------------------------------------------------------------------------
// herald_cmd_port_if
//   Request/result bus between the command port and the downstream engine mux.
//   master (command port): drives eng_cmd, eng_a, eng_b, eng_start, eng_abort;
//                          receives eng_ready, eng_done, eng_res.
//   slave  (engine mux):   the mirror image.
//   OPW  : operand width in bits (multiple of 8)
//   RESW : result bus width in bits
// -----------------------------------------------------------------------------
interface herald_cmd_port_if #(
  parameter int OPW  = 24,
  parameter int RESW = 72
);
  logic [7:0]      eng_cmd;
  logic [OPW-1:0]  eng_a;
  logic [OPW-1:0]  eng_b;
  logic            eng_start;
  logic            eng_ready;
  logic            eng_done;
  logic [RESW-1:0] eng_res;
  logic            eng_abort;

  modport master (
    output eng_cmd, eng_a, eng_b, eng_start, eng_abort,
    input  eng_ready, eng_done, eng_res
  );

  modport slave (
    input  eng_cmd, eng_a, eng_b, eng_start, eng_abort,
    output eng_ready, eng_done, eng_res
  );
endinterface

// File: rtl/herald_strobe_sync.sv
// -----------------------------------------------------------------------------
// herald_strobe_sync
//   Brings an asynchronous host strobe into the clk domain (2-flop
//   synchroniser) and emits a one-cycle pulse on its rising edge.
//   clk, rst_n : clock, asynchronous active-low reset
//   pin        : raw asynchronous strobe
//   rise       : one-cycle pulse, high in the cycle after the 2nd sync flop
//                first sees the pin high
// -----------------------------------------------------------------------------
module herald_strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic rise
);
  // [0] and [1] form the synchroniser; [2] is the history bit for the edge.
  logic [2:0] sh;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes this a shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sh <= '0;
    else        sh <= {sh[1:0], pin};
  end

  assign rise = sh[1] & ~sh[2];
endmodule

// File: rtl/herald_cmd_port.sv
// -----------------------------------------------------------------------------
// herald_cmd_port
//   Byte-serial host command port for the Herald co-processor. Collects a
//   command byte and up to two OPW-bit operands (LSB byte first) over an 8-bit
//   strobe bus, issues them to the engine mux with a valid/ready handshake and
//   streams the result back one byte per read strobe (LSB first).
//
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     din        : host data byte
//     wr, rd     : asynchronous host write / read strobes
//     abort      : synchronous level abort, returns the port to IDLE
//     dout       : registered read data (status in IDLE, result in RESULT)
//     busy       : high while collecting operands or waiting on the engine
//     err        : sticky error, cleared by a status read in IDLE
//     eng        : engine bus (herald_cmd_port_if.master)
//
//   Build option HERALD_RESULT_CSUM_EN: when defined, a non-empty result is
//   followed by one extra byte, the XOR of all result bytes.
// -----------------------------------------------------------------------------
module herald_cmd_port
  import herald_pkg::*;
#(
  parameter int OPW  = 24,
  parameter int RESW = 72
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] din,
  input  logic       wr,
  input  logic       rd,
  input  logic       abort,
  output logic [7:0] dout,
  output logic       busy,
  output logic       err,
  herald_cmd_port_if.master eng
);
  localparam int NB    = OPW / 8;
  localparam int CNT_W = 4;

  state_t            state;
  logic [CNT_W-1:0]  cnt;      // operand byte index, or result byte index
  logic [RESW-1:0]   res_q;    // captured result, shifted down as bytes are read
  logic              wr_rise;
  logic              rd_rise;
  logic [1:0]        ops_new;
  logic [1:0]        ops_cur;
  logic [CNT_W-1:0]  nres;
  logic [OPW-1:0]    din_shift;
  logic              op_last;
`ifdef HERALD_RESULT_CSUM_EN
  logic [7:0]        csum;
`endif

  herald_strobe_sync u_wr_sync (.clk(clk), .rst_n(rst_n), .pin(wr), .rise(wr_rise));
  herald_strobe_sync u_rd_sync (.clk(clk), .rst_n(rst_n), .pin(rd), .rise(rd_rise));

  assign ops_new   = cmd_num_ops(din);
  assign ops_cur   = cmd_num_ops(eng.eng_cmd);
  assign nres      = cmd_res_bytes(eng.eng_cmd);
  // Operand registers are cleared when a command is accepted, so OR-ing the
  // byte into its lane is enough to load it.
  assign din_shift = OPW'(din) << {cnt, 3'b000};
  assign op_last   = (cnt == CNT_W'(NB - 1));
  assign busy      = state inside {ST_OPA, ST_OPB, ST_START, ST_WAIT};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      cnt             <= '0;
      dout            <= '0;
      err             <= 1'b0;
      res_q           <= '0;
      eng.eng_cmd     <= '0;
      eng.eng_a       <= '0;
      eng.eng_b       <= '0;
      eng.eng_start   <= 1'b0;
      eng.eng_abort   <= 1'b0;
`ifdef HERALD_RESULT_CSUM_EN
      csum            <= '0;
`endif
    end else begin
      eng.eng_abort <= 1'b0;
      if (abort && state != ST_IDLE) begin
        state         <= ST_IDLE;
        cnt           <= '0;
        eng.eng_start <= 1'b0;
        eng.eng_abort <= 1'b1;
      end else if (wr_rise && (state == ST_IDLE || state == ST_RESULT)) begin
        // A write in RESULT abandons the unread bytes and starts over, and it
        // takes priority over a read strobe arriving in the same cycle.
        eng.eng_cmd <= din;
        eng.eng_a   <= '0;
        eng.eng_b   <= '0;
        cnt         <= '0;
        if (ops_new == OPS_INVALID) begin
          err   <= 1'b1;
          state <= ST_IDLE;
        end else if (ops_new == 2'd0) begin
          state <= ST_START;
        end else begin
          state <= ST_OPA;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (rd_rise) begin
              dout <= {err, 7'h00};
              err  <= 1'b0;
            end
          end
          ST_OPA: begin
            if (wr_rise) begin
              eng.eng_a <= eng.eng_a | din_shift;
              if (op_last) begin
                cnt   <= '0;
                state <= (ops_cur == 2'd2) ? ST_OPB : ST_START;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          ST_OPB: begin
            if (wr_rise) begin
              eng.eng_b <= eng.eng_b | din_shift;
              if (op_last) begin
                cnt   <= '0;
                state <= ST_START;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
            end
          end
          ST_START: begin
            if (wr_rise) err <= 1'b1;
            // eng_start rises one cycle after entry and falls on the transfer.
            if (eng.eng_start && eng.eng_ready) begin
              eng.eng_start <= 1'b0;
              state         <= ST_WAIT;
            end else begin
              eng.eng_start <= 1'b1;
            end
          end
          ST_WAIT: begin
            if (wr_rise) err <= 1'b1;
            if (eng.eng_done) begin
              res_q <= eng.eng_res;
              cnt   <= '0;
`ifdef HERALD_RESULT_CSUM_EN
              csum  <= '0;
`endif
              state <= (nres == '0) ? ST_IDLE : ST_RESULT;
            end
          end
          ST_RESULT: begin
            if (rd_rise) begin
`ifdef HERALD_RESULT_CSUM_EN
              if (cnt == nres) begin
                dout  <= csum;
                cnt   <= '0;
                state <= ST_IDLE;
              end else begin
                dout  <= res_q[7:0];
                res_q <= res_q >> 8;
                csum  <= csum ^ res_q[7:0];
                cnt   <= cnt + CNT_W'(1);
              end
`else
              dout  <= res_q[7:0];
              res_q <= res_q >> 8;
              if (cnt == nres - CNT_W'(1)) begin
                cnt   <= '0;
                state <= ST_IDLE;
              end else begin
                cnt <= cnt + CNT_W'(1);
              end
`endif
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_herald_cmd_port.sv
// -----------------------------------------------------------------------------
// tb_herald_cmd_port
//   Self-checking bench for herald_cmd_port: a table of per-command properties
//   applied in a loop, hand-written corner-case sequences, and randomized
//   transactions whose read-back bytes come from a byte-queue reference model.
// -----------------------------------------------------------------------------
module tb_herald_cmd_port;
  import herald_pkg::*;

  typedef struct {
    logic [7:0] cmd;
    int         ops;
    int         nres;
    bit         bad;
  } vec_t;

  localparam int NV = 11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] din;
  logic       wr, rd, abort;
  logic [7:0] dout;
  logic       busy, err;
  logic [7:0] exp_dout;
  int         checks = 0;
  int         errors = 0;
  vec_t       vecs [NV];

  herald_cmd_port_if #(.OPW(24), .RESW(72)) eng_if ();

  herald_cmd_port #(.OPW(24), .RESW(72)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .wr(wr), .rd(rd), .abort(abort),
    .dout(dout), .busy(busy), .err(err), .eng(eng_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic host_wr(input logic [7:0] b);
    @(negedge clk); din = b; wr = 1'b1;
    repeat (4) @(negedge clk);
    wr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic host_rd(output logic [7:0] v);
    @(negedge clk); rd = 1'b1;
    repeat (4) @(negedge clk);
    v = dout; rd = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (eng_if.eng_start === 1'b1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("eng_start_seen", ok, 1);
  endtask

  // Engine holds ready low for rdy cycles, then accepts in one cycle.
  task automatic handshake(input int rdy);
    for (int i = 0; i < rdy; i++) begin
      @(negedge clk);
      check("eng_start_held", eng_if.eng_start, 1);
    end
    eng_if.eng_ready = 1'b1;
    @(negedge clk);
    eng_if.eng_ready = 1'b0;
    check("eng_start_drop", eng_if.eng_start, 0);
    check("busy_in_wait", busy, 1);
  endtask

  task automatic engine_done(input logic [71:0] res);
    repeat (2) @(negedge clk);
    eng_if.eng_done = 1'b1; eng_if.eng_res = res;
    @(negedge clk);
    eng_if.eng_done = 1'b0;
    check("busy_after_done", busy, 0);
  endtask

  // Reference model: the result is a queue of its low nres bytes, LSB first,
  // optionally followed by their XOR.
  task automatic read_result(input int nres, input logic [71:0] res);
    logic [7:0] q[$];
    logic [7:0] x, v;
    x = 8'h00;
    for (int k = 0; k < nres; k++) q.push_back(res[8*k +: 8]);
    for (int k = 0; k < nres; k++) begin
      host_rd(v);
      check($sformatf("res_byte%0d", k), v, q[k]);
      x ^= q[k];
      exp_dout = q[k];
    end
`ifdef HERALD_RESULT_CSUM_EN
    if (nres > 0) begin
      host_rd(v);
      check("res_csum", v, x);
      exp_dout = x;
    end
`endif
    check("state_idle_after_result", dut.state, ST_IDLE);
  endtask

  task automatic run_cmd(input logic [7:0] cmd, input int ops, input int nres,
                         input logic [23:0] a, input logic [23:0] b,
                         input logic [71:0] res, input int rdy);
    bit ok;
    host_wr(cmd);
    check("eng_cmd_latched", eng_if.eng_cmd, cmd);
    check("busy_after_cmd", busy, 1);
    if (ops >= 1) for (int i = 0; i < 3; i++) host_wr(a[8*i +: 8]);
    if (ops >= 2) for (int i = 0; i < 3; i++) host_wr(b[8*i +: 8]);
    wait_start(ok);
    if (ok) begin
      if (ops >= 1) check("eng_a", eng_if.eng_a, a);
      if (ops >= 2) check("eng_b", eng_if.eng_b, b);
      handshake(rdy);
      engine_done(res);
      read_result(nres, res);
    end
  endtask

  task automatic do_vec(input vec_t v, input logic [23:0] a, input logic [23:0] b,
                        input logic [71:0] res, input int rdy);
    logic [7:0] s;
    if (v.bad) begin
      host_wr(v.cmd);
      check("bad_cmd_err", err, 1);
      check("bad_cmd_busy", busy, 0);
      check("bad_cmd_state", dut.state, ST_IDLE);
      host_rd(s);
      check("bad_cmd_status", s, 8'h80);
      exp_dout = 8'h80;
    end else begin
      run_cmd(v.cmd, v.ops, v.nres, a, b, res, rdy);
    end
  endtask

  initial begin
    logic [7:0] v;
    bit         ok;

    vecs[0]  = '{8'h10, 1, 6, 1'b0};
    vecs[1]  = '{8'h11, 1, 3, 1'b0};
    vecs[2]  = '{8'h12, 1, 3, 1'b0};
    vecs[3]  = '{8'h13, 1, 9, 1'b0};
    vecs[4]  = '{8'h20, 2, 3, 1'b0};
    vecs[5]  = '{8'h21, 2, 3, 1'b0};
    vecs[6]  = '{8'h22, 0, 0, 1'b0};
    vecs[7]  = '{8'h23, 0, 3, 1'b0};
    vecs[8]  = '{8'h7F, 0, 0, 1'b1};
    vecs[9]  = '{8'h00, 0, 0, 1'b1};
    vecs[10] = '{8'h14, 0, 0, 1'b1};

    rst_n = 1'b0; din = 8'h00; wr = 1'b0; rd = 1'b0; abort = 1'b0;
    eng_if.eng_ready = 1'b0; eng_if.eng_done = 1'b0; eng_if.eng_res = '0;
    exp_dout = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_eng_cmd", eng_if.eng_cmd, 0);
    check("rst_eng_start", eng_if.eng_start, 0);
    check("rst_eng_abort", eng_if.eng_abort, 0);
    check("rst_state", dut.state, ST_IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // MULTIPLY: ready held low 3 cycles.
    run_cmd(8'h20, 2, 3, 24'h001000, 24'h002000, 72'h002000, 3);

    // SINCOS: six result bytes (plus checksum when enabled).
    run_cmd(8'h10, 1, 6, 24'h123456, 24'h000000, 72'h0AFFEE112233, 1);

    // Unknown command and status reads.
    host_wr(8'h7F);
    check("unk_err", err, 1);
    check("unk_state", dut.state, ST_IDLE);
    host_rd(v); check("status_first", v, 8'h80);
    host_rd(v); check("status_second", v, 8'h00);
    check("err_cleared", err, 0);
    exp_dout = 8'h00;

    // CLEAR: no operands, no result; a write during WAIT sets err.
    host_wr(8'h22);
    wait_start(ok);
    if (ok) begin
      handshake(0);
      host_wr(8'h55);
      check("wr_in_wait_err", err, 1);
      check("wr_in_wait_busy", busy, 1);
      engine_done(72'h0);
      check("clear_idle", dut.state, ST_IDLE);
    end
    host_rd(v); check("clear_status", v, 8'h80);
    exp_dout = 8'h80;

    // Abort during WAIT.
    host_wr(8'h20);
    for (int i = 0; i < 6; i++) host_wr(8'h11);
    wait_start(ok);
    if (ok) handshake(0);
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_pulse", eng_if.eng_abort, 1);
    check("abort_state", dut.state, ST_IDLE);
    check("abort_start_low", eng_if.eng_start, 0);
    check("abort_err_kept", err, 0);
    @(negedge clk);
    check("abort_pulse_once", eng_if.eng_abort, 0);
    eng_if.eng_done = 1'b1; eng_if.eng_res = 72'h123456;
    @(negedge clk); eng_if.eng_done = 1'b0;
    @(negedge clk);
    check("done_ignored_state", dut.state, ST_IDLE);
    check("done_ignored_dout", dout, exp_dout);
    run_cmd(8'h11, 1, 3, 24'hABCDEF, 24'h0, 72'h778899, 0);

    // Write and read together in RESULT: the new command wins.
    host_wr(8'h11);
    for (int i = 0; i < 3; i++) host_wr(8'h01);
    wait_start(ok);
    if (ok) begin
      handshake(0);
      engine_done(72'hC0B0A0);
      host_rd(v); check("partial_byte0", v, 8'hA0);
      @(negedge clk); din = 8'h22; wr = 1'b1; rd = 1'b1;
      repeat (4) @(negedge clk);
      wr = 1'b0; rd = 1'b0;
      repeat (4) @(negedge clk);
      check("wr_wins_dout", dout, 8'hA0);
      check("wr_wins_cmd", eng_if.eng_cmd, 8'h22);
      check("wr_wins_busy", busy, 1);
      wait_start(ok);
      if (ok) begin
        handshake(0);
        engine_done(72'h0);
        check("wr_wins_idle", dut.state, ST_IDLE);
      end
    end

    // Reset mid-OPB: outputs clear asynchronously.
    host_wr(8'h21);
    for (int i = 0; i < 4; i++) host_wr(8'h44);
    check("in_opb", dut.state, ST_OPB);
    @(negedge clk); #2 rst_n = 1'b0; #1;
    check("arst_dout", dout, 0);
    check("arst_busy", busy, 0);
    check("arst_eng_cmd", eng_if.eng_cmd, 0);
    check("arst_eng_a", eng_if.eng_a, 0);
    check("arst_eng_b", eng_if.eng_b, 0);
    check("arst_state", dut.state, ST_IDLE);
    @(negedge clk); rst_n = 1'b1;
    exp_dout = 8'h00;

    // Table-driven pass with fixed data.
    for (int i = 0; i < NV; i++)
      do_vec(vecs[i], 24'h030201 + 24'(i), 24'h0C0B0A - 24'(i),
             72'h998877665544332211 ^ 72'(i * 8'h13), i % 3);

    // Randomized pass.
    for (int n = 0; n < 30; n++)
      do_vec(vecs[$urandom_range(0, NV - 1)], 24'($urandom), 24'($urandom),
             {8'($urandom), $urandom, $urandom}, int'($urandom_range(0, 3)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
